lsm_sequencer: RTL
==================

Name: lsm_sequencer

Overview:
- Parametrised load/store-multiple sequencer for the ARM datapath, phase 2 (memory interface present).
- Started by the control unit when it detects an LDM/STM. Walks the register list and generates one memory transfer per set bit.
- Drives the register-file index, the memory address and the memory request, and handshakes on MOC with memory.
- On completion it optionally writes back the base register, then pulses LSM_END back to the control unit.

Parameters:
- NREGS, 16: number of bits in the register list and number of addressable registers.
- IDXW, 4: width of the register index; must satisfy 2^IDXW >= NREGS.
- AW, 32: address width.
- WORD_BYTES, 4: address step per transfer.
- TIMEOUT_CYCLES, 64: watchdog limit; used only when LSM_TIMEOUT_EN is defined.

Ports:
- CLK  in  1  rising-edge clock
- RST_N  in  1  asynchronous active-low reset
- START  in  1  start request from the control unit; sampled only in IDLE
- REG_LIST  in  NREGS  register list (IR[15:0]); latched on START
- BASE_ADDR  in  AW  base register value (Rn); latched on START
- P_BIT  in  1  pre-index (IR[24]); latched on START
- U_BIT  in  1  up/down (IR[23]); latched on START
- W_BIT  in  1  writeback (IR[21]); latched on START
- L_BIT  in  1  1 = load, 0 = store (IR[20]); latched on START
- MOC  in  1  memory operation complete
- ADDR  out  AW  transfer address
- REG_IDX  out  IDXW  register being transferred
- MEM_REQ  out  1  memory request (MFA)
- MEM_RW  out  1  1 = read, 0 = write; equals the latched L_BIT
- RF_LD  out  1  register-file load strobe for LDM
- WB_EN  out  1  base-register writeback strobe
- WB_VALUE  out  AW  writeback value
- BUSY  out  1  high whenever the state is not IDLE
- LSM_END  out  1  one-cycle completion pulse
- ABORT  out  1  watchdog abort pulse; constant 0 without LSM_TIMEOUT_EN

Behaviour:
- States: IDLE, SETUP, XFER, WB, DONE.
- Reset (asynchronous, RST_N=0):
  - state returns to IDLE;
  - every output is 0, including ADDR, REG_IDX and WB_VALUE;
  - latched list, count and address are cleared.
- Reset mid-operation aborts immediately. No further strobes are produced after RST_N deasserts.
- IDLE: START=1 at an edge latches all inputs and moves to SETUP. START is ignored in every other state.
- SETUP (1 cycle):
  - CNT = popcount(list); OFF = CNT*WORD_BYTES. Arithmetic is AW bits, modulo 2^AW; wrap is not flagged.
  - Start address by mode:
    - IA (P=0, U=1): base
    - IB (P=1, U=1): base + WORD_BYTES
    - DA (P=0, U=0): base - OFF + WORD_BYTES
    - DB (P=1, U=0): base - OFF
  - WB_VALUE = U ? base + OFF : base - OFF, registered here and held until the next SETUP.
  - If CNT = 0, go to DONE: no transfers and no writeback. Otherwise go to XFER.
- XFER:
  - MEM_REQ=1, ADDR = current address, REG_IDX = lowest set bit of the remaining list.
  - Outputs are stable while MOC=0.
  - On an edge with MOC=1:
    - RF_LD is high in that same cycle (combinational with MOC, gated by L).
    - Clear that list bit; ADDR += WORD_BYTES.
    - If the remaining list is now empty, go to WB if W=1, else to DONE. Otherwise stay in XFER.
  - Registers are always transferred in ascending index order at ascending addresses.
  - MOC outside XFER is ignored.
- WB (1 cycle): WB_EN=1. WB_VALUE is as computed in SETUP.
- DONE (1 cycle): LSM_END=1, then return to IDLE.
- Latency, N registers with MOC tied high: START edge, then 1 SETUP + N XFER + W WB + 1 DONE cycles; BUSY lasts N+2+W cycles.
- MEM_REQ deasserts in the cycle after the final MOC.

Optional Feature:
- Macro LSM_TIMEOUT_EN.
- Defined:
  - A counter clears on entry to XFER and after each accepted MOC, and increments each XFER cycle with MOC=0.
  - On reaching TIMEOUT_CYCLES: ABORT pulses 1 cycle, MEM_REQ drops, and the state goes directly to DONE, skipping WB. LSM_END still pulses.
- Undefined: no counter logic; ABORT is tied to 0; XFER waits indefinitely for MOC.

Test Plan:
- LDMIA base 0x100, list 0x000B, W=0, MOC=1 -> ADDR 0x100/0x104/0x108, REG_IDX 0/1/3, RF_LD on each, MEM_RW=1, no WB_EN, LSM_END 4 cycles after SETUP.
- STMDB base 0x200, list 0xC000, W=1, MOC=1 -> ADDR 0x1F8/0x1FC, REG_IDX 14/15, MEM_RW=0, RF_LD=0, WB_EN with WB_VALUE 0x1F8, then LSM_END.
- LDMIB base 0x40, list 0x0001, MOC delayed 3 cycles -> ADDR 0x44, REG_IDX 0 held for 4 cycles, single RF_LD, LSM_END.
- LDMDA base 0x40, list 0x0006, W=1 -> ADDR 0x3C/0x40, REG_IDX 1/2, WB_VALUE 0x38.
- Empty list, W=1 -> SETUP then DONE; no MEM_REQ, no WB_EN, LSM_END=1; a START in SETUP is ignored.
- Reset and timeout:
  - RST_N=0 during the second XFER of a 3-register LDM -> all outputs 0 asynchronously, IDLE; a new START runs cleanly.
  - With LSM_TIMEOUT_EN and MOC held 0 -> ABORT after 64 cycles, then LSM_END, no WB_EN.

Source files
------------

// File: rtl/lsm_sequencer.sv
// Load/store-multiple sequencer: walks an LDM/STM register list, issuing one memory
// transfer per set bit with MFA/MOC handshake. Optional watchdog enabled by LSM_TIMEOUT_EN.
module lsm_sequencer #(
  parameter int NREGS          = 16,
  parameter int IDXW           = 4,
  parameter int AW             = 32,
  parameter int WORD_BYTES     = 4,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             START,
  input  logic [NREGS-1:0] REG_LIST,
  input  logic [AW-1:0]    BASE_ADDR,
  input  logic             P_BIT,
  input  logic             U_BIT,
  input  logic             W_BIT,
  input  logic             L_BIT,
  input  logic             MOC,
  output logic [AW-1:0]    ADDR,
  output logic [IDXW-1:0]  REG_IDX,
  output logic             MEM_REQ,
  output logic             MEM_RW,
  output logic             RF_LD,
  output logic             WB_EN,
  output logic [AW-1:0]    WB_VALUE,
  output logic             BUSY,
  output logic             LSM_END,
  output logic             ABORT
);

  localparam logic [AW-1:0] STEP = AW'(WORD_BYTES);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_XFER,
    S_WB,
    S_DONE
  } state_e;

  typedef struct packed {
    logic p;
    logic u;
    logic w;
    logic l;
  } mode_t;

  state_e           state_q, state_d;
  logic [NREGS-1:0] list_q, list_d;
  logic [AW-1:0]    base_q, base_d;
  logic [AW-1:0]    addr_q, addr_d;
  logic [AW-1:0]    wb_value_q, wb_value_d;
  mode_t            mode_q, mode_d;

  logic [AW-1:0]    cnt;
  logic [AW-1:0]    off;
  logic [AW-1:0]    start_addr;
  logic [IDXW-1:0]  low_idx;
  logic [NREGS-1:0] list_rest;
  logic             last_xfer;
  logic             tmo_hit;

  // Transfer count and total byte span, computed from the latched list during SETUP.
  always_comb begin
    // NOTE: every variable assigned in always_comb gets a default first so no latch is inferred.
    cnt = '0;
    for (int i = 0; i < NREGS; i++) begin
      cnt = cnt + AW'(list_q[i]);
    end
    off = cnt * STEP;
  end

  // Lowest transfer address; registers always go out ascending from here.
  always_comb begin
    start_addr = base_q;
    unique case ({mode_q.p, mode_q.u})
      2'b01:   start_addr = base_q;
      2'b11:   start_addr = base_q + STEP;
      2'b00:   start_addr = base_q - off + STEP;
      default: start_addr = base_q - off;
    endcase
  end

  always_comb begin
    low_idx = '0;
    for (int i = NREGS - 1; i >= 0; i--) begin
      if (list_q[i]) low_idx = IDXW'(i);
    end
  end

  // Clearing the lowest set bit gives the list left after the current transfer.
  assign list_rest = list_q & (list_q - NREGS'(1));
  assign last_xfer = (list_rest == '0);

`ifdef LSM_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  logic [TW-1:0] tmo_q, tmo_d;

  // Counts consecutive XFER cycles without MOC; held at zero everywhere else.
  always_comb begin
    tmo_d = '0;
    if (state_q == S_XFER && !MOC) tmo_d = tmo_q + TW'(1);
  end

  assign tmo_hit = (state_q == S_XFER) && !MOC && (tmo_q == TW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) tmo_q <= '0;
    else        tmo_q <= tmo_d;
  end
`else
  assign tmo_hit = 1'b0;
`endif

  // State register
  always_ff @(posedge CLK or negedge RST_N) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (!RST_N) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (START) state_d = S_SETUP;
      S_SETUP: state_d = (list_q == '0) ? S_DONE : S_XFER;
      S_XFER: begin
        if (MOC) begin
          if (last_xfer) state_d = mode_q.w ? S_WB : S_DONE;
        end else if (tmo_hit) begin
          state_d = S_DONE;
        end
      end
      S_WB:    state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath next-state: operand latch, address walk and writeback value.
  always_comb begin
    list_d     = list_q;
    base_d     = base_q;
    mode_d     = mode_q;
    addr_d     = addr_q;
    wb_value_d = wb_value_q;
    unique case (state_q)
      S_IDLE: begin
        if (START) begin
          list_d = REG_LIST;
          base_d = BASE_ADDR;
          mode_d = '{p: P_BIT, u: U_BIT, w: W_BIT, l: L_BIT};
        end
      end
      S_SETUP: begin
        addr_d     = start_addr;
        wb_value_d = mode_q.u ? base_q + off : base_q - off;
      end
      S_XFER: begin
        if (MOC) begin
          list_d = list_rest;
          addr_d = addr_q + STEP;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      list_q     <= '0;
      base_q     <= '0;
      mode_q     <= '0;
      addr_q     <= '0;
      wb_value_q <= '0;
    end else begin
      list_q     <= list_d;
      base_q     <= base_d;
      mode_q     <= mode_d;
      addr_q     <= addr_d;
      wb_value_q <= wb_value_d;
    end
  end

  // Output logic
  always_comb begin
    ADDR     = '0;
    REG_IDX  = '0;
    MEM_REQ  = 1'b0;
    RF_LD    = 1'b0;
    WB_EN    = 1'b0;
    LSM_END  = 1'b0;
    MEM_RW   = mode_q.l;
    WB_VALUE = wb_value_q;
    BUSY     = (state_q != S_IDLE);
    ABORT    = tmo_hit;
    unique case (state_q)
      S_XFER: begin
        MEM_REQ = 1'b1;
        ADDR    = addr_q;
        REG_IDX = low_idx;
        RF_LD   = MOC & mode_q.l;
      end
      S_WB:    WB_EN   = 1'b1;
      S_DONE:  LSM_END = 1'b1;
      default: ;
    endcase
  end

endmodule
